dct2d_param: RTL

- Parametrised successor to the fixed 8x8 2-D DCT engine.
- Computes an NxN forward transform (Y = C·X·Cᵀ) or inverse transform (X = Cᵀ·Y·C) as two separable matrix passes through an internal transpose buffer.
- Coefficients come from an external coefficient ROM. Input comes from an external block RAM. Results go out through a single write port.
- Adds run-time forward/inverse mode, rounding, saturation with a sticky flag, and generic size and widths.

---
 rtl/dct2d_param.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dct2d_param.sv
// NxN 2-D forward/inverse DCT engine: two separable MAC passes (A*X, then T*A^T)
// through an internal transpose buffer, with round-half-up and sticky saturation.
module dct2d_param #(
  parameter int N    = 8,
  parameter int LOGN = 3,
  parameter int IW   = 8,
  parameter int MW   = 16,
  parameter int FRAC = 14,
  parameter int OW   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              mode,
  output logic              rdy,
  output logic              sat,
  output logic [2*LOGN-1:0] iaddr,
  input  logic [IW-1:0]     iq,
  output logic [2*LOGN-1:0] maddr,
  input  logic [MW-1:0]     mq,
  output logic [2*LOGN-1:0] waddr,
  output logic [OW-1:0]     wdata,
  output logic              wwren
);

  localparam int XW = (IW > OW) ? IW : OW;
  localparam int PW = XW + MW;
  localparam int AW = XW + MW + LOGN;
  localparam logic signed [AW-1:0] HALF = AW'(1 << (FRAC - 1));
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (OW - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2} state_t;

  state_t                 r_state;
  logic                   r_mode;
  logic                   r_sat;
  logic [LOGN-1:0]        r_i;
  logic [LOGN-1:0]        r_j;
  logic [LOGN:0]          r_k;
  logic signed [AW-1:0]   r_acc;
  logic                   r_wwren;
  logic [2*LOGN-1:0]      r_waddr;
  logic [OW-1:0]          r_wdata;
  logic [OW-1:0]          r_tbuf [N*N];

  logic                   w_mac;
  logic                   w_last;
  logic [LOGN-1:0]        w_kl;
  logic [LOGN-1:0]        w_row;
  logic signed [XW-1:0]   w_opnd;
  logic signed [PW-1:0]   w_prod;
  logic signed [AW-1:0]   w_base;
  logic signed [AW-1:0]   w_acc_nxt;
  logic signed [AW-1:0]   w_sum;
  logic signed [AW-1:0]   w_rnd;
  logic                   w_clip;
  logic [OW-1:0]          w_res;

  // k == N marks the writeback cycle; k < N are MAC cycles
  assign w_kl   = r_k[LOGN-1:0];
  assign w_mac  = (r_state != IDLE) && !r_k[LOGN];
  assign w_last = w_mac && (w_kl == LOGN'(N - 1));
  assign w_row  = (r_state == PASS1) ? r_i : r_j;

  assign rdy   = (r_state == IDLE);
  assign sat   = r_sat;
  assign wwren = r_wwren;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign iaddr = (w_mac && r_state == PASS1) ? {w_kl, r_j} : '0;
  assign maddr = w_mac ? (r_mode ? {w_kl, w_row} : {w_row, w_kl}) : '0;

  always_comb begin
    if (r_state == PASS1) w_opnd = XW'($signed(iq));
    else                  w_opnd = XW'($signed(r_tbuf[{r_i, w_kl}]));
    w_prod    = w_opnd * $signed(mq);
    w_base    = (r_k == '0) ? '0 : r_acc;
    w_acc_nxt = w_base + AW'(w_prod);
    w_sum     = w_acc_nxt + HALF;
    w_rnd     = w_sum >>> FRAC;
    w_clip    = 1'b0;
    w_res     = w_rnd[OW-1:0];
    if (w_rnd > MAXV) begin
      w_clip = 1'b1;
      w_res  = MAXV[OW-1:0];
    end else if (w_rnd < MINV) begin
      w_clip = 1'b1;
      w_res  = MINV[OW-1:0];
    end
  end

  // Results are formed from the final MAC sum so the writeback cycle sees them registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_sat   <= 1'b0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_wwren <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wwren <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state <= PASS1;
            r_mode  <= mode;
            r_sat   <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
          end
        end
        PASS1, PASS2: begin
          if (w_mac) begin
            r_acc <= w_acc_nxt;
            r_k   <= r_k + 1'b1;
            if (w_last) begin
              if (w_clip) r_sat <= 1'b1;
              if (r_state == PASS2) begin
                r_wwren <= 1'b1;
                r_waddr <= {r_i, r_j};
                r_wdata <= w_res;
              end
            end
          end else begin
            r_k <= '0;
            r_j <= r_j + 1'b1;
            if (r_j == LOGN'(N - 1)) begin
              r_i <= r_i + 1'b1;
              if (r_i == LOGN'(N - 1))
                r_state <= (r_state == PASS1) ? PASS2 : IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == PASS1 && w_last) r_tbuf[{r_i, r_j}] <= w_res;
  end

endmodule
